// File: rtl/clk_div_multi_if.sv
// Configuration port of clk_div_multi: valid/ready request carrying the
// target channel, period and high time, plus the one-cycle reject pulse.
interface clk_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_high,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_high,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with double-buffered configuration
// that takes effect only at period boundaries, plus a global phase-align sync.
module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    clk_div_multi_if.slave    cfg,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_DIV / 2);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
    localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0] pending;
    logic              cfg_ready_int;
    logic              cfg_bad;
    logic              cfg_xfer;
    logic              cfg_wr;
    logic              cfg_err_reg;

    // Out-of-range channels never match, so they read as ready and get rejected.
    always_comb begin
        cfg_ready_int = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                cfg_ready_int = ~pending[i];
            end
        end
    end

    assign cfg_bad   = (cfg.cfg_div < TWO) || (cfg.cfg_high > cfg.cfg_div) ||
                       ({1'b0, cfg.cfg_ch} >= NUM_CH_V);
    assign cfg_xfer  = cfg.cfg_valid && cfg_ready_int;
    assign cfg_wr    = cfg_xfer && !cfg_bad;
    assign cfg.cfg_ready = cfg_ready_int;
    assign cfg.cfg_err   = cfg_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_xfer && cfg_bad;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] div_reg;
        logic [CNT_W-1:0] high_reg;
        logic [CNT_W-1:0] sh_div_reg;
        logic [CNT_W-1:0] sh_high_reg;
        logic [CNT_W-1:0] cnt_reg;
        logic             pending_reg;
        logic             div_out_reg;
        logic             tick_reg;
        logic             wr;
        logic             wrap;
        logic [CNT_W-1:0] new_div;
        logic [CNT_W-1:0] new_high;
        logic [CNT_W-1:0] cnt_next;

        assign wr       = cfg_wr && (cfg.cfg_ch == CH_W'(gi));
        assign wrap     = (cnt_reg == div_reg - ONE) || sync;
        assign new_div  = pending_reg ? sh_div_reg  : div_reg;
        assign new_high = pending_reg ? sh_high_reg : high_reg;
        assign cnt_next = cnt_reg + ONE;

        always_ff @(posedge clk) begin
            if (rst) begin
                div_reg     <= DEF_DIV;
                high_reg    <= DEF_HIGH;
                sh_div_reg  <= DEF_DIV;
                sh_high_reg <= DEF_HIGH;
                cnt_reg     <= DEF_DIV - ONE;
                pending_reg <= 1'b0;
                div_out_reg <= 1'b0;
                tick_reg    <= 1'b0;
            end else if (!ch_en[gi]) begin
                // Parking at div-1 makes the first enabled edge a wrap.
                div_out_reg <= 1'b0;
                tick_reg    <= 1'b0;
                pending_reg <= 1'b0;
                if (wr) begin
                    div_reg  <= cfg.cfg_div;
                    high_reg <= cfg.cfg_high;
                    cnt_reg  <= cfg.cfg_div - ONE;
                end else begin
                    div_reg  <= new_div;
                    high_reg <= new_high;
                    cnt_reg  <= new_div - ONE;
                end
            end else begin
                if (wrap) begin
                    div_reg     <= new_div;
                    high_reg    <= new_high;
                    pending_reg <= 1'b0;
                    cnt_reg     <= '0;
                    tick_reg    <= 1'b1;
                    div_out_reg <= (new_high != '0);
                end else begin
                    cnt_reg     <= cnt_next;
                    tick_reg    <= 1'b0;
                    div_out_reg <= (cnt_next < high_reg);
                end
                // A write on a wrap edge still waits for the following wrap.
                if (wr) begin
                    sh_div_reg  <= cfg.cfg_div;
                    sh_high_reg <= cfg.cfg_high;
                    pending_reg <= 1'b1;
                end
            end
        end

        assign pending[gi] = pending_reg;
        assign div_out[gi] = div_out_reg;
        assign tick[gi]    = tick_reg;
    end
endmodule
